// File: rtl/branch_unit.sv
// In-order branch resolution unit: buffers conditional branches until their operands
// are ready, evaluates them at the head, and presents {pc, taken} to the CDB arbiter.
module branch_unit #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 5
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             issue_valid,
    input  logic [2:0]       issue_op,
    input  logic [31:0]      issue_pc,
    input  logic             issue_rs1_rdy,
    input  logic             issue_rs2_rdy,
    input  logic [31:0]      issue_rs1_val,
    input  logic [31:0]      issue_rs2_val,
    input  logic [TAG_W-1:0] issue_rs1_tag,
    input  logic [TAG_W-1:0] issue_rs2_tag,
    output logic             full,
    input  logic             cdb_in_active,
    input  logic [TAG_W-1:0] cdb_in_tag,
    input  logic [31:0]      cdb_in_val,
    input  logic             flush_in,
    output logic             out_valid,
    output logic [31:0]      out_addr,
    output logic [31:0]      out_val,
    input  logic             out_grant
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    typedef struct packed {
        logic [2:0]       op;
        logic [31:0]      pc;
        logic             rs1_rdy;
        logic [31:0]      rs1_val;
        logic [TAG_W-1:0] rs1_tag;
        logic             rs2_rdy;
        logic [31:0]      rs2_val;
        logic [TAG_W-1:0] rs2_tag;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [PTR_W-1:0] head, tail;
    logic [PTR_W:0]   count;

    entry_t new_entry;
    logic   do_issue, do_load, head_ok, head_taken;

    function automatic logic eval_branch(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
        case (op)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) <  $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a <  b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    assign full       = (count == FULL_CNT);
    assign do_issue   = issue_valid && !full && !flush_in;
    assign head_ok    = valid[head] && mem[head].rs1_rdy && mem[head].rs2_rdy;
    assign head_taken = eval_branch(mem[head].op, mem[head].rs1_val, mem[head].rs2_val);
    assign do_load    = head_ok && (!out_valid || out_grant) && !flush_in;

    // The issuing branch also snoops the CDB so a same-cycle broadcast is not missed.
    always_comb begin
        new_entry         = '0;
        new_entry.op      = issue_op;
        new_entry.pc      = issue_pc;
        new_entry.rs1_tag = issue_rs1_tag;
        new_entry.rs2_tag = issue_rs2_tag;
        new_entry.rs1_rdy = issue_rs1_rdy || (cdb_in_active && issue_rs1_tag == cdb_in_tag);
        new_entry.rs2_rdy = issue_rs2_rdy || (cdb_in_active && issue_rs2_tag == cdb_in_tag);
        new_entry.rs1_val = issue_rs1_rdy ? issue_rs1_val : cdb_in_val;
        new_entry.rs2_val = issue_rs2_rdy ? issue_rs2_val : cdb_in_val;
    end

    // NOTE: entry payload needs no reset; the separately reset valid bits decide what is live.
    always_ff @(posedge clk_in) begin
        if (rdy_in && !flush_in) begin
            if (cdb_in_active) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (valid[i] && !mem[i].rs1_rdy && mem[i].rs1_tag == cdb_in_tag) begin
                        mem[i].rs1_rdy <= 1'b1;
                        mem[i].rs1_val <= cdb_in_val;
                    end
                    if (valid[i] && !mem[i].rs2_rdy && mem[i].rs2_tag == cdb_in_tag) begin
                        mem[i].rs2_rdy <= 1'b1;
                        mem[i].rs2_val <= cdb_in_val;
                    end
                end
            end
            if (do_issue) mem[tail] <= new_entry;
        end
    end

    // NOTE: all state uses non-blocking assignments so every read sees pre-edge values.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            valid     <= '0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_val   <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                valid     <= '0;
                head      <= '0;
                tail      <= '0;
                count     <= '0;
                out_valid <= 1'b0;
                out_addr  <= '0;
                out_val   <= '0;
            end else begin
                if (do_issue) begin
                    valid[tail] <= 1'b1;
                    tail        <= tail + 1'b1;
                end
                if (do_load) begin
                    out_valid   <= 1'b1;
                    out_addr    <= mem[head].pc;
                    out_val     <= {31'b0, head_taken};
                    valid[head] <= 1'b0;
                    head        <= head + 1'b1;
                end else if (out_grant) begin
                    out_valid <= 1'b0;
                end
                case ({do_issue, do_load})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_branch_unit.sv
// Scoreboard bench for branch_unit: stimulus pushes expected {pc, taken} broadcasts,
// a negedge monitor pops and compares on every granted broadcast.
module tb_branch_unit;

    logic        clk_in, rst_in, rdy_in;
    logic        issue_valid;
    logic [2:0]  issue_op;
    logic [31:0] issue_pc;
    logic        issue_rs1_rdy, issue_rs2_rdy;
    logic [31:0] issue_rs1_val, issue_rs2_val;
    logic [4:0]  issue_rs1_tag, issue_rs2_tag;
    logic        full;
    logic        cdb_in_active;
    logic [4:0]  cdb_in_tag;
    logic [31:0] cdb_in_val;
    logic        flush_in;
    logic        out_valid;
    logic [31:0] out_addr, out_val;
    logic        out_grant;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [2:0] BEQ = 3'b000, BNE = 3'b001, BLT = 3'b100, BGE = 3'b101,
                           BLTU = 3'b110, BGEU = 3'b111;

    branch_unit #(.DEPTH(4), .TAG_W(5)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_valid(issue_valid), .issue_op(issue_op), .issue_pc(issue_pc),
        .issue_rs1_rdy(issue_rs1_rdy), .issue_rs2_rdy(issue_rs2_rdy),
        .issue_rs1_val(issue_rs1_val), .issue_rs2_val(issue_rs2_val),
        .issue_rs1_tag(issue_rs1_tag), .issue_rs2_tag(issue_rs2_tag),
        .full(full),
        .cdb_in_active(cdb_in_active), .cdb_in_tag(cdb_in_tag), .cdb_in_val(cdb_in_val),
        .flush_in(flush_in),
        .out_valid(out_valid), .out_addr(out_addr), .out_val(out_val),
        .out_grant(out_grant)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a broadcast is consumed on the edge after a negedge that sees valid && grant.
    always @(negedge clk_in) begin
        if (rst_in && rdy_in && !flush_in && out_valid && out_grant) begin
            exp_t e;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_bcast: got addr %h expected none", out_addr);
            end else begin
                e = sb.pop_front();
                check("bcast_addr", out_addr, e.addr);
                check("bcast_val", out_val, e.val);
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] pc,
                         input logic r1_rdy, input logic [31:0] r1_val, input logic [4:0] r1_tag,
                         input logic r2_rdy, input logic [31:0] r2_val, input logic [4:0] r2_tag,
                         input bit push, input logic taken);
        issue_valid   = 1'b1;
        issue_op      = op;
        issue_pc      = pc;
        issue_rs1_rdy = r1_rdy;
        issue_rs1_val = r1_val;
        issue_rs1_tag = r1_tag;
        issue_rs2_rdy = r2_rdy;
        issue_rs2_val = r2_val;
        issue_rs2_tag = r2_tag;
        if (push) sb.push_back('{addr: pc, val: {31'b0, taken}});
        tick();
        issue_valid = 1'b0;
    endtask

    task automatic issue_rdy(input logic [2:0] op, input logic [31:0] pc,
                             input logic [31:0] a, input logic [31:0] b,
                             input bit push, input logic taken);
        issue(op, pc, 1'b1, a, 5'd0, 1'b1, b, 5'd0, push, taken);
    endtask

    task automatic drain();
        int n = 0;
        out_grant = 1'b1;
        while ((sb.size() != 0 || out_valid) && n < 60) begin
            tick();
            n++;
        end
        check("drain_done", 32'(sb.size() == 0 && !out_valid), 32'd1);
    endtask

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; issue_valid = 1'b0; issue_op = '0; issue_pc = '0;
        issue_rs1_rdy = 1'b0; issue_rs2_rdy = 1'b0; issue_rs1_val = '0; issue_rs2_val = '0;
        issue_rs1_tag = '0; issue_rs2_tag = '0; cdb_in_active = 1'b0; cdb_in_tag = '0;
        cdb_in_val = '0; flush_in = 1'b0; out_grant = 1'b0;

        #23;
        check("rst_full", 32'(full), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_addr", out_addr, 32'd0);
        check("rst_out_val", out_val, 32'd0);
        @(negedge clk_in) rst_in = 1'b1;
        tick();

        // BEQ 5 vs 5: two-cycle latency, drop after grant
        issue_rdy(BEQ, 32'h100, 32'd5, 32'd5, 1, 1'b1);
        check("beq_lat_early", 32'(out_valid), 32'd0);
        tick();
        check("beq_valid", 32'(out_valid), 32'd1);
        check("beq_addr", out_addr, 32'h100);
        check("beq_val", out_val, 32'd1);
        out_grant = 1'b1;
        tick();
        out_grant = 1'b0;
        check("beq_drop", 32'(out_valid), 32'd0);

        // compare flavours, issued back to back with grant held
        out_grant = 1'b1;
        issue_rdy(BLT,  32'h110, 32'hFFFF_FFFF, 32'd1, 1, 1'b1);
        issue_rdy(BLTU, 32'h114, 32'hFFFF_FFFF, 32'd1, 1, 1'b0);
        issue_rdy(BGEU, 32'h118, 32'd7, 32'd7, 1, 1'b1);
        issue_rdy(BNE,  32'h11C, 32'd3, 32'd4, 1, 1'b1);
        issue_rdy(BGE,  32'h120, 32'hFFFF_FFFF, 32'd1, 1, 1'b0);
        issue_rdy(3'b010, 32'h124, 32'd1, 32'd1, 1, 1'b0);
        tick();
        check("throughput_valid", 32'(out_valid), 32'd1);
        drain();

        // ordering: unready head blocks an evaluable younger entry
        issue(BEQ, 32'h200, 1'b0, 32'd0, 5'd3, 1'b1, 32'd0, 5'd0, 1, 1'b1);
        issue_rdy(BNE, 32'h204, 32'd1, 32'd2, 1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("order_blocked", 32'(out_valid), 32'd0);
            tick();
        end
        cdb_in_active = 1'b1; cdb_in_tag = 5'd3; cdb_in_val = 32'd0;
        tick();
        cdb_in_active = 1'b0;
        check("snoop_capture_lat", 32'(out_valid), 32'd0);
        tick();
        check("snoop_load_valid", 32'(out_valid), 32'd1);
        check("snoop_load_addr", out_addr, 32'h200);
        drain();

        // same-cycle snoop on issue: rs2 tag 7 satisfied by CDB value 9
        cdb_in_active = 1'b1; cdb_in_tag = 5'd7; cdb_in_val = 32'd9;
        issue(BEQ, 32'h300, 1'b1, 32'd9, 5'd0, 1'b0, 32'd0, 5'd7, 1, 1'b1);
        cdb_in_active = 1'b0;
        drain();

        // full boundary: one in the output register plus four buffered
        out_grant = 1'b0;
        for (int i = 0; i < 5; i++)
            issue_rdy(BEQ, 32'h400 + 32'(4 * i), 32'd1, 32'd1, 1, 1'b1);
        check("full_set", 32'(full), 32'd1);
        check("full_head_addr", out_addr, 32'h400);
        issue_rdy(BEQ, 32'h500, 32'd1, 32'd1, 0, 1'b0);
        check("full_hold", 32'(full), 32'd1);
        out_grant = 1'b1;
        issue_rdy(BEQ, 32'h504, 32'd1, 32'd1, 0, 1'b0);
        check("full_drop_after_pop", 32'(full), 32'd0);
        drain();

        // flush with issue and grant in the same cycle
        out_grant = 1'b0;
        for (int i = 0; i < 4; i++)
            issue_rdy(BEQ, 32'h600 + 32'(4 * i), 32'd1, 32'd1, 0, 1'b1);
        check("flush_pre_valid", 32'(out_valid), 32'd1);
        flush_in = 1'b1; out_grant = 1'b1;
        issue_rdy(BEQ, 32'h700, 32'd1, 32'd1, 0, 1'b1);
        flush_in = 1'b0;
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_full", 32'(full), 32'd0);
        check("flush_addr", out_addr, 32'd0);
        check("flush_val", out_val, 32'd0);
        tick(); tick(); tick();
        check("flush_stays_empty", 32'(out_valid), 32'd0);
        issue_rdy(BLTU, 32'h800, 32'd1, 32'd2, 1, 1'b1);
        drain();

        // rdy_in low freezes state and ignores grant and issue
        out_grant = 1'b0;
        issue_rdy(BEQ, 32'h900, 32'd1, 32'd1, 1, 1'b1);
        tick();
        check("stall_pre_valid", 32'(out_valid), 32'd1);
        rdy_in = 1'b0; out_grant = 1'b1;
        issue_valid = 1'b1; issue_pc = 32'h904; issue_op = BEQ;
        issue_rs1_rdy = 1'b1; issue_rs2_rdy = 1'b1;
        tick(); tick();
        issue_valid = 1'b0;
        check("stall_hold_valid", 32'(out_valid), 32'd1);
        check("stall_hold_addr", out_addr, 32'h900);
        rdy_in = 1'b1;
        drain();

        // asynchronous reset mid-stream
        out_grant = 1'b0;
        issue_rdy(BEQ, 32'hA00, 32'd1, 32'd1, 0, 1'b1);
        issue_rdy(BEQ, 32'hA04, 32'd1, 32'd1, 0, 1'b1);
        check("arst_pre_valid", 32'(out_valid), 32'd1);
        #2 rst_in = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_addr", out_addr, 32'd0);
        check("arst_full", 32'(full), 32'd0);
        @(negedge clk_in) rst_in = 1'b1;
        tick(); tick();
        check("arst_stays_idle", 32'(out_valid), 32'd0);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
